// File: rtl/opcode_sequencer.sv
// opcode_sequencer: steps a 16-bit opcode program on each start pulse. Core words are broadcast
// with an execute strobe; control words (HALT/SETLOOP/LOOP/NOP) run locally. SEQ_CYCLE_COUNTER_EN adds run_cycles.
module opcode_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(PROG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [15:0]           prog_data,
  input  logic                  start,
  output logic [15:0]           opcode,
  output logic                  execute,
  output logic                  busy,
  output logic                  done
`ifdef SEQ_CYCLE_COUNTER_EN
  ,
  output logic [7:0]            run_cycles
`endif
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] SUB_HALT    = 2'b00;
  localparam logic [1:0] SUB_SETLOOP = 2'b01;
  localparam logic [1:0] SUB_LOOP    = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_DEPTH - 1);

  state_t                state_p0, state_nxt;
  logic [ADDR_WIDTH-1:0] pc_p0, pc_nxt;
  logic [4:0]            loop_cnt_p0, loop_cnt_nxt;
  logic                  end_pend_p0, end_pend_nxt;
  logic [15:0]           prog [PROG_DEPTH];
  logic [15:0]           word_p0;
  logic                  is_ctrl_p0, halt_p0, jump_p0;
  logic [15:0]           opcode_nxt;
  logic                  execute_nxt, done_nxt;

  // Stage p0: combinational fetch and decode of prog[pc]
  assign word_p0    = prog[pc_p0];
  assign is_ctrl_p0 = (word_p0[15:14] == 2'b11) && word_p0[7];
  // end_pend_p0 is the implicit HALT after the last address; the fetched word is ignored then
  assign halt_p0    = end_pend_p0 || (is_ctrl_p0 && (word_p0[6:5] == SUB_HALT));
  assign jump_p0    = is_ctrl_p0 && (word_p0[6:5] == SUB_LOOP) && (loop_cnt_p0 != 5'd0);
  assign busy       = (state_p0 == RUN);

  always_ff @(posedge clk) begin
    if (prog_we && (state_p0 == IDLE) && !start) begin
      prog[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0    <= IDLE;
      pc_p0       <= '0;
      loop_cnt_p0 <= '0;
      end_pend_p0 <= 1'b0;
      opcode      <= '0;
      execute     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      pc_p0       <= pc_nxt;
      loop_cnt_p0 <= loop_cnt_nxt;
      end_pend_p0 <= end_pend_nxt;
      opcode      <= opcode_nxt;
      execute     <= execute_nxt;
      done        <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_p0;
    pc_nxt       = pc_p0;
    loop_cnt_nxt = loop_cnt_p0;
    end_pend_nxt = end_pend_p0;
    unique case (state_p0)
      IDLE: begin
        if (start) begin
          state_nxt    = RUN;
          pc_nxt       = '0;
          end_pend_nxt = 1'b0;
        end
      end
      RUN: begin
        if (halt_p0) begin
          state_nxt    = IDLE;
          pc_nxt       = '0;
          end_pend_nxt = 1'b0;
        end else begin
          pc_nxt = pc_p0 + ADDR_WIDTH'(1);
          if (is_ctrl_p0 && (word_p0[6:5] == SUB_SETLOOP)) begin
            loop_cnt_nxt = word_p0[13:9];
          end
          if (jump_p0) begin
            loop_cnt_nxt = loop_cnt_p0 - 5'd1;
            pc_nxt       = word_p0[ADDR_WIDTH-1:0];
          end
          // The last word still runs; no wrap, so flag an implicit HALT for next cycle
          if ((pc_p0 == LAST_ADDR) && !jump_p0) begin
            end_pend_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered broadcast outputs
  always_comb begin
    opcode_nxt  = opcode;
    execute_nxt = 1'b0;
    done_nxt    = 1'b0;
    if (state_p0 == RUN) begin
      if (halt_p0) begin
        done_nxt = 1'b1;
      end else if (!is_ctrl_p0) begin
        opcode_nxt  = word_p0;
        execute_nxt = 1'b1;
      end
    end
  end

`ifdef SEQ_CYCLE_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cycles <= '0;
    end else if ((state_p0 == IDLE) && start) begin
      run_cycles <= '0;
    end else if (execute_nxt && (run_cycles != 8'hFF)) begin
      run_cycles <= run_cycles + 8'd1;
    end
  end
`endif

endmodule
